// File: rtl/vga_sync_gen_pkg.sv
// vga_sync_gen_pkg
//   Shared raster timing constants for the VGA output path: default
//   640x480@60 timing, default sync polarity, position and frame counter
//   widths, plus a small helper for half-open window tests.
//   Downstream pixel stages import this package to stay in step with the
//   sync generator.
package vga_sync_gen_pkg;

   localparam int POS_W     = 10;
   localparam int FRAME_W   = 8;
   localparam int POS_LIMIT = 1 << POS_W;

   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;
   localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   localparam bit DEF_SYNC_ACTIVE_LOW = 1'b1;

   // True when lo <= pos < lo+len.
   function automatic logic in_window(input logic [POS_W-1:0] pos, input int lo, input int len);
      int p;
      p = int'(pos);
      return (p >= lo) && (p < lo + len);
   endfunction

endpackage

// File: rtl/vga_sync_gen_wrap_counter.sv
// wrap_counter
//   Up-counter that advances on en_i and wraps from MAX to 0.
//   Ports:
//     clk_i, rst_n_i  clock, asynchronous active-low reset (count -> RST_VAL)
//     en_i            advance enable
//     count_o         registered count
//     count_next_o    value the count takes on the next edge
//     wrap_o          high when the next edge wraps MAX -> 0
//   count_next_o lets the parent register decoded flags that line up with
//   the new count on the same edge.
module wrap_counter #(
   parameter int W       = 10,
   parameter int MAX     = 799,
   parameter int RST_VAL = MAX
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         en_i,
   output logic [W-1:0] count_o,
   output logic [W-1:0] count_next_o,
   output logic         wrap_o
);

   localparam logic [W-1:0] MAX_C = W'(MAX);
   localparam logic [W-1:0] RST_C = W'(RST_VAL);

   logic [W-1:0] count_q, count_d;
   logic         wrap_d;

   always_comb begin
      wrap_d  = en_i && (count_q == MAX_C);
      count_d = count_q;
      if (wrap_d) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_q <= RST_C;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o      = count_q;
   assign count_next_o = count_d;
   assign wrap_o       = wrap_d;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   Raster timing generator: pixel position, visible flag, hsync/vsync,
//   line/frame start strobes and an 8-bit frame counter. Every output is
//   registered from the next-position values, so all outputs in a cycle
//   describe the same pixel.
//   Ports:
//     i_clk, i_rst_n   pixel clock, asynchronous active-low reset
//     i_ce             pixel advance enable
//     o_hpos, o_vpos   current column / line
//     o_visible        inside the active area
//     o_hsync, o_vsync sync pulses, polarity set by SYNC_ACTIVE_LOW
//     o_line_start     one-clock strobe when hpos enters 0
//     o_frame_start    one-clock strobe when position enters (0,0)
//     o_frame          frame counter, wraps 255 -> 0
module vga_sync_gen
   import vga_sync_gen_pkg::*;
#(
   parameter int H_VISIBLE       = DEF_H_VISIBLE,
   parameter int H_FRONT         = DEF_H_FRONT,
   parameter int H_SYNC          = DEF_H_SYNC,
   parameter int H_BACK          = DEF_H_BACK,
   parameter int V_VISIBLE       = DEF_V_VISIBLE,
   parameter int V_FRONT         = DEF_V_FRONT,
   parameter int V_SYNC          = DEF_V_SYNC,
   parameter int V_BACK          = DEF_V_BACK,
   parameter bit SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_ce,
   output logic [POS_W-1:0]   o_hpos,
   output logic [POS_W-1:0]   o_vpos,
   output logic               o_visible,
   output logic               o_hsync,
   output logic               o_vsync,
   output logic               o_line_start,
   output logic               o_frame_start,
   output logic [FRAME_W-1:0] o_frame
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam logic [POS_W-1:0] V_LAST = POS_W'(V_TOTAL - 1);
   localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

   if (H_TOTAL > POS_LIMIT) begin : g_h_total_check
      $error("vga_sync_gen: H_TOTAL=%0d exceeds %0d", H_TOTAL, POS_LIMIT);
   end
   if (V_TOTAL > POS_LIMIT) begin : g_v_total_check
      $error("vga_sync_gen: V_TOTAL=%0d exceeds %0d", V_TOTAL, POS_LIMIT);
   end

   logic [POS_W-1:0] hpos, hpos_next, vpos, vpos_next;
   logic             h_wrap, v_wrap;

   wrap_counter #(.W(POS_W), .MAX(H_TOTAL - 1)) u_hcnt (
      .clk_i       (i_clk),
      .rst_n_i     (i_rst_n),
      .en_i        (i_ce),
      .count_o     (hpos),
      .count_next_o(hpos_next),
      .wrap_o      (h_wrap)
   );

   // Vertical counter steps only on the horizontal wrap, so vsync and
   // vpos change on the same edge as hpos returns to 0.
   wrap_counter #(.W(POS_W), .MAX(V_TOTAL - 1)) u_vcnt (
      .clk_i       (i_clk),
      .rst_n_i     (i_rst_n),
      .en_i        (h_wrap),
      .count_o     (vpos),
      .count_next_o(vpos_next),
      .wrap_o      ()
   );

   assign v_wrap = h_wrap && (vpos == V_LAST);

   logic               visible_d, hsync_d, vsync_d;
   logic [FRAME_W-1:0] frame_d;
   logic               visible_q, hsync_q, vsync_q;
   logic               line_start_q, frame_start_q, started_q;
   logic [FRAME_W-1:0] frame_q;

   always_comb begin
      visible_d = (int'(hpos_next) < H_VISIBLE) && (int'(vpos_next) < V_VISIBLE);
      hsync_d   = in_window(hpos_next, H_VISIBLE + H_FRONT, H_SYNC) ^ SYNC_ACTIVE_LOW;
      vsync_d   = in_window(vpos_next, V_VISIBLE + V_FRONT, V_SYNC) ^ SYNC_ACTIVE_LOW;
      // The wrap out of the reset parking position (last pixel of the
      // last line) starts frame 0, so it does not count as a completed frame.
      frame_d   = frame_q;
      if (v_wrap && started_q) begin
         frame_d = frame_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         visible_q     <= 1'b0;
         hsync_q       <= SYNC_IDLE;
         vsync_q       <= SYNC_IDLE;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         started_q     <= 1'b0;
         frame_q       <= '0;
      end else begin
         visible_q     <= visible_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         line_start_q  <= h_wrap;
         frame_start_q <= v_wrap;
         started_q     <= started_q | i_ce;
         frame_q       <= frame_d;
      end
   end

   assign o_hpos        = hpos;
   assign o_vpos        = vpos;
   assign o_visible     = visible_q;
   assign o_hsync       = hsync_q;
   assign o_vsync       = vsync_q;
   assign o_line_start  = line_start_q;
   assign o_frame_start = frame_start_q;
   assign o_frame       = frame_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
//   Default-timing instance: reset values, first ticks, clock-enable holds,
//   one full line and an asynchronous mid-line reset.
//   Two reduced-timing instances (sync active low / active high) run from
//   random clock enables over more than 256 frames against a model that
//   derives position from the number of ticks since reset.
module tb_vga_sync_gen;

   localparam int SH_VIS = 8, SH_FP = 2, SH_SW = 3, SH_BP = 2;
   localparam int SH_T   = SH_VIS + SH_FP + SH_SW + SH_BP;
   localparam int SV_VIS = 5, SV_FP = 1, SV_SW = 2, SV_BP = 2;
   localparam int SV_T   = SV_VIS + SV_FP + SV_SW + SV_BP;
   localparam int SF_T   = SH_T * SV_T;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       vis;
      logic       hs;
      logic       vs;
      logic       ls;
      logic       fs;
      logic [7:0] fr;
   } obs_t;

   typedef struct {
      logic ce;
      int   h;
      int   v;
      logic vis;
      logic ls;
      logic fs;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_d_n = 1'b0, ce_d = 1'b0;
   logic rst_s_n = 1'b0, ce_s = 1'b0;

   logic [9:0] d_h, d_v, s_h, s_v, p_h, p_v;
   logic       d_vis, d_hs, d_vs, d_ls, d_fs;
   logic       s_vis, s_hs, s_vs, s_ls, s_fs;
   logic       p_vis, p_hs, p_vs, p_ls, p_fs;
   logic [7:0] d_fr, s_fr, p_fr;

   vga_sync_gen dut_d (
      .i_clk(clk), .i_rst_n(rst_d_n), .i_ce(ce_d),
      .o_hpos(d_h), .o_vpos(d_v), .o_visible(d_vis), .o_hsync(d_hs), .o_vsync(d_vs),
      .o_line_start(d_ls), .o_frame_start(d_fs), .o_frame(d_fr)
   );

   vga_sync_gen #(
      .H_VISIBLE(SH_VIS), .H_FRONT(SH_FP), .H_SYNC(SH_SW), .H_BACK(SH_BP),
      .V_VISIBLE(SV_VIS), .V_FRONT(SV_FP), .V_SYNC(SV_SW), .V_BACK(SV_BP),
      .SYNC_ACTIVE_LOW(1'b1)
   ) dut_s (
      .i_clk(clk), .i_rst_n(rst_s_n), .i_ce(ce_s),
      .o_hpos(s_h), .o_vpos(s_v), .o_visible(s_vis), .o_hsync(s_hs), .o_vsync(s_vs),
      .o_line_start(s_ls), .o_frame_start(s_fs), .o_frame(s_fr)
   );

   vga_sync_gen #(
      .H_VISIBLE(SH_VIS), .H_FRONT(SH_FP), .H_SYNC(SH_SW), .H_BACK(SH_BP),
      .V_VISIBLE(SV_VIS), .V_FRONT(SV_FP), .V_SYNC(SV_SW), .V_BACK(SV_BP),
      .SYNC_ACTIVE_LOW(1'b0)
   ) dut_p (
      .i_clk(clk), .i_rst_n(rst_s_n), .i_ce(ce_s),
      .o_hpos(p_h), .o_vpos(p_v), .o_visible(p_vis), .o_hsync(p_hs), .o_vsync(p_vs),
      .o_line_start(p_ls), .o_frame_start(p_fs), .o_frame(p_fr)
   );

   int errors = 0;
   int checks = 0;
   int n_s    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (tick %0d): got h=%0d v=%0d vis=%b hs=%b vs=%b ls=%b fs=%b fr=%0d expected h=%0d v=%0d vis=%b hs=%b vs=%b ls=%b fs=%b fr=%0d",
                  name, n_s, act.h, act.v, act.vis, act.hs, act.vs, act.ls, act.fs, act.fr,
                  exp.h, exp.v, exp.vis, exp.hs, exp.vs, exp.ls, exp.fs, exp.fr);
      end
   endtask

   // Reference raster: after n ticks the beam has advanced n-1 pixels past
   // (0,0); the frame count is the number of whole frames completed since then.
   function automatic obs_t model(input int n, input logic tick, input logic pol);
      obs_t o;
      int   p, h, v;
      if (n == 0) begin
         o.h = 10'(SH_T - 1); o.v = 10'(SV_T - 1);
         o.vis = 1'b0; o.hs = pol; o.vs = pol; o.ls = 1'b0; o.fs = 1'b0; o.fr = 8'd0;
         return o;
      end
      p = (n - 1) % SF_T;
      h = p % SH_T;
      v = p / SH_T;
      o.h   = 10'(h);
      o.v   = 10'(v);
      o.vis = (h < SH_VIS) && (v < SV_VIS);
      o.hs  = ((h >= SH_VIS + SH_FP) && (h < SH_VIS + SH_FP + SH_SW)) ^ pol;
      o.vs  = ((v >= SV_VIS + SV_FP) && (v < SV_VIS + SV_FP + SV_SW)) ^ pol;
      o.ls  = tick && (h == 0);
      o.fs  = tick && (p == 0);
      o.fr  = 8'(((n - 1) / SF_T) % 256);
      return o;
   endfunction

   function automatic obs_t obs_s();
      return {s_h, s_v, s_vis, s_hs, s_vs, s_ls, s_fs, s_fr};
   endfunction

   function automatic obs_t obs_p();
      return {p_h, p_v, p_vis, p_hs, p_vs, p_ls, p_fs, p_fr};
   endfunction

   task automatic step_s(input logic ce);
      ce_s = ce;
      @(posedge clk);
      #1;
      if (ce) n_s++;
      chk_obs("small_lo", obs_s(), model(n_s, ce, 1'b1));
      chk_obs("small_hi", obs_p(), model(n_s, ce, 1'b0));
   endtask

   task automatic chk_d_reset(input string tag);
      chk({tag, "_hpos"},  32'(d_h),  32'd799);
      chk({tag, "_vpos"},  32'(d_v),  32'd524);
      chk({tag, "_vis"},   32'(d_vis), 32'd0);
      chk({tag, "_hsync"}, 32'(d_hs), 32'd1);
      chk({tag, "_vsync"}, 32'(d_vs), 32'd1);
      chk({tag, "_ls"},    32'(d_ls), 32'd0);
      chk({tag, "_fs"},    32'(d_fs), 32'd0);
      chk({tag, "_frame"}, 32'(d_fr), 32'd0);
   endtask

   initial begin
      vec_t vecs[6];
      int   exp_h, exp_v, hs_low, cyc, target;
      logic saw_wrap;

      vecs[0] = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b1};
      vecs[1] = '{1'b1, 1, 0, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 1, 0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 1, 0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 2, 0, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 3, 0, 1'b1, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      chk_d_reset("rst");
      chk_obs("small_lo_rst", obs_s(), model(0, 1'b0, 1'b1));
      chk_obs("small_hi_rst", obs_p(), model(0, 1'b0, 1'b0));
      rst_d_n = 1'b1;

      // Reset release, first ticks and held cycles.
      foreach (vecs[i]) begin
         ce_d = vecs[i].ce;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_hpos", i), 32'(d_h), 32'(vecs[i].h));
         chk($sformatf("vec%0d_vpos", i), 32'(d_v), 32'(vecs[i].v));
         chk($sformatf("vec%0d_vis", i),  32'(d_vis), 32'(vecs[i].vis));
         chk($sformatf("vec%0d_ls", i),   32'(d_ls), 32'(vecs[i].ls));
         chk($sformatf("vec%0d_fs", i),   32'(d_fs), 32'(vecs[i].fs));
         chk($sformatf("vec%0d_frame", i), 32'(d_fr), 32'd0);
      end

      // Rest of line 0 and the wrap into line 1.
      ce_d   = 1'b1;
      exp_h  = 3;
      hs_low = 0;
      for (int k = 0; k < 797; k++) begin
         @(posedge clk);
         #1;
         exp_h = (exp_h + 1) % 800;
         exp_v = (exp_h == 0) ? 1 : 0;
         if (d_hs == 1'b0) hs_low++;
         chk("line_hpos", 32'(d_h), 32'(exp_h));
         chk("line_vpos", 32'(d_v), 32'(exp_v));
         chk("line_vis",  32'(d_vis), (exp_h < 640) ? 32'd1 : 32'd0);
         chk("line_hsync", 32'(d_hs), (exp_h >= 656 && exp_h < 752) ? 32'd0 : 32'd1);
         chk("line_vsync", 32'(d_vs), 32'd1);
         chk("line_ls", 32'(d_ls), (exp_h == 0) ? 32'd1 : 32'd0);
         chk("line_fs", 32'(d_fs), 32'd0);
      end
      chk("hsync_low_clocks", 32'(hs_low), 32'd96);

      // Advance to hpos=300 on line 1, then reset between edges.
      for (int k = 0; k < 300; k++) begin
         @(posedge clk);
         #1;
      end
      chk("pre_rst_hpos", 32'(d_h), 32'd300);
      chk("pre_rst_vpos", 32'(d_v), 32'd1);
      #3;
      rst_d_n = 1'b0;
      #1;
      chk_d_reset("async_rst");
      @(posedge clk);
      #1;
      rst_d_n = 1'b1;
      @(posedge clk);
      #1;
      chk("resume_hpos", 32'(d_h), 32'd0);
      chk("resume_vpos", 32'(d_v), 32'd0);
      chk("resume_fs",   32'(d_fs), 32'd1);
      chk("resume_ls",   32'(d_ls), 32'd1);
      chk("resume_frame", 32'(d_fr), 32'd0);
      ce_d = 1'b0;

      // Reduced-timing instances: random enables, mid-frame async reset.
      rst_s_n = 1'b1;
      n_s     = 0;
      for (int k = 0; k < 100; k++) step_s(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      #3;
      rst_s_n = 1'b0;
      #1;
      chk_obs("small_lo_async", obs_s(), model(0, 1'b0, 1'b1));
      chk_obs("small_hi_async", obs_p(), model(0, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      chk_obs("small_lo_held", obs_s(), model(0, 1'b0, 1'b1));
      rst_s_n = 1'b1;
      n_s     = 0;

      // Long run past the 255 -> 0 frame wrap.
      target   = 256 * SF_T + 2 * SF_T;
      cyc      = 0;
      saw_wrap = 1'b0;
      while (n_s < target && cyc < 70000) begin
         step_s(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0);
         cyc++;
         if (s_fs && n_s == 256 * SF_T + 1) begin
            saw_wrap = 1'b1;
            chk("frame_wrap_lo", 32'(s_fr), 32'd0);
            chk("frame_wrap_hi", 32'(p_fr), 32'd0);
         end
      end
      chk("long_run_reached", (n_s >= target) ? 32'd1 : 32'd0, 32'd1);
      chk("frame_wrap_seen", 32'(saw_wrap), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
